// File: rtl/average_accumulator.sv
// Per-bank windowed average of 9-lane RAM beats; beat-to-accumulator 2 cycles, result valid 4 cycles after finish.
// No backpressure: a beat is accepted every cycle while accumulating, beats in any other state are dropped.
module average_accumulator #(
    parameter int DATA_W = 16,
    parameter int LANES  = 9,
    parameter int BANKS  = 3,
    parameter int SHIFT  = 12
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_resetAverage,
    input  logic                            i_writeEnable,
    input  logic                            i_mask,
    input  logic                            i_finish,
    input  logic [BANKS*LANES*DATA_W-1:0]   i_data,
    output logic [BANKS*DATA_W-1:0]         o_avg,
    output logic                            o_valid,
    output logic                            o_busy,
    output logic                            o_countErr
);

    localparam int SUM_W  = DATA_W + 4;
    localparam int ACC_W  = DATA_W + SHIFT + 1;
    localparam int CNT_W  = SHIFT + 2;
    localparam int BEAT_W = $clog2(LANES + 1);

    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] AVG_MAX = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] AVG_MIN = ~AVG_MAX;
    localparam logic [CNT_W-1:0]      WINDOW  = CNT_W'(2 ** SHIFT);

    typedef enum logic [1:0] {ACC, DRAIN, ROUND, DONE} state_t;

    state_t state;
    state_t nextState;
    logic   drainCnt;
    logic   acceptBeat;
    logic   doRound;

    logic signed [SUM_W-1:0]  laneSum  [BANKS];
    logic signed [SUM_W-1:0]  s1Sum    [BANKS];
    logic [BEAT_W-1:0]        s1Cnt;
    logic                     s1Vld;
    logic signed [ACC_W-1:0]  acc      [BANKS];
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           cntSum;
    logic signed [ACC_W:0]    rounded  [BANKS];
    logic [DATA_W-1:0]        avgNext  [BANKS];

    // State register; drainCnt times the two DRAIN cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ACC;
            drainCnt <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= i_resetAverage && (state == DRAIN) && !drainCnt;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ACC:     if (i_finish) nextState = DRAIN;
            DRAIN:   if (drainCnt) nextState = ROUND;
            ROUND:   nextState = DONE;
            DONE:    nextState = DONE;
            default: nextState = ACC;
        endcase
        if (!i_resetAverage) nextState = ACC;
    end

    always_comb begin
        acceptBeat = (state == ACC) && i_writeEnable && i_resetAverage;
        doRound    = (state == ROUND);
    end

    // Masked lane sum: lane 0 always counts, the rest only on full beats
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            laneSum[b] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (l == 0 || i_mask)
                    laneSum[b] = laneSum[b] + SUM_W'($signed(i_data[(b*LANES+l)*DATA_W +: DATA_W]));
            end
        end
    end

    always_comb begin
        cntSum = {1'b0, count} + (CNT_W+1)'(s1Cnt);
        for (int b = 0; b < BANKS; b++) begin
            rounded[b] = ((ACC_W+1)'(acc[b]) + HALF) >>> SHIFT;
            if (rounded[b] > AVG_MAX)
                avgNext[b] = AVG_MAX[DATA_W-1:0];
            else if (rounded[b] < AVG_MIN)
                avgNext[b] = AVG_MIN[DATA_W-1:0];
            else
                avgNext[b] = rounded[b][DATA_W-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int b = 0; b < BANKS; b++) begin
                s1Sum[b] <= '0;
                acc[b]   <= '0;
            end
            s1Cnt      <= '0;
            s1Vld      <= 1'b0;
            count      <= '0;
            o_avg      <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_countErr <= 1'b0;
        end else if (!i_resetAverage) begin
            for (int b = 0; b < BANKS; b++) begin
                s1Sum[b] <= '0;
                acc[b]   <= '0;
            end
            s1Cnt   <= '0;
            s1Vld   <= 1'b0;
            count   <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            s1Vld <= acceptBeat;
            if (acceptBeat) begin
                for (int b = 0; b < BANKS; b++) s1Sum[b] <= laneSum[b];
                s1Cnt <= i_mask ? BEAT_W'(LANES) : BEAT_W'(1);
            end
            if (s1Vld) begin
                for (int b = 0; b < BANKS; b++) acc[b] <= acc[b] + ACC_W'(s1Sum[b]);
                count <= cntSum[CNT_W] ? '1 : cntSum[CNT_W-1:0];
            end
            o_valid <= doRound;
            if (doRound) begin
                for (int b = 0; b < BANKS; b++) o_avg[b*DATA_W +: DATA_W] <= avgNext[b];
                o_countErr <= (count != WINDOW);
                o_busy     <= 1'b0;
            end else if (acceptBeat) begin
                o_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_average_accumulator.sv
// Randomized bench for average_accumulator: element-level reference model feeding a scoreboard.
module tb_average_accumulator;

    localparam int DW = 16;
    localparam int LN = 9;
    localparam int BK = 3;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_resetAverage = 1'b1;
    logic                 i_writeEnable = 1'b0;
    logic                 i_mask = 1'b0;
    logic                 i_finish = 1'b0;
    logic [BK*LN*DW-1:0]  i_data = '0;
    logic [BK*DW-1:0]     o_avg;
    logic                 o_valid;
    logic                 o_busy;
    logic                 o_countErr;

    average_accumulator dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_resetAverage(i_resetAverage),
        .i_writeEnable(i_writeEnable), .i_mask(i_mask), .i_finish(i_finish),
        .i_data(i_data), .o_avg(o_avg), .o_valid(o_valid), .o_busy(o_busy),
        .o_countErr(o_countErr)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc = cyc + 1;

    typedef struct packed {
        logic [BK*DW-1:0] avg;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t   sbQ[$];
    int     nCmp = 0;
    int     nErr = 0;
    longint mSum [BK];
    int     mCnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (o_valid) begin
            if (sbQ.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                for (int b = 0; b < BK; b++)
                    check($sformatf("avg_bank%0d", b), longint'($signed(o_avg[b*DW +: DW])),
                          longint'($signed(e.avg[b*DW +: DW])));
                check("countErr", longint'(o_countErr), longint'(e.err));
                check("valid_latency", longint'(cyc), longint'(e.cyc));
                check("busy_at_valid", longint'(o_busy), 0);
            end
        end
    end

    function automatic longint elemVal(input int kind, input int b, input int idx);
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        case (kind)
            0: return 1;
            1: return (b == 0) ? 3 : (b == 1) ? -2 : ((idx % 2 == 0) ? 32767 : -32768);
            2: return (b == 0) ? ((idx < 2048) ? 1 : 0) : (b == 1) ? ((idx < 2049) ? -1 : 0) : longint'(r);
            3: return 5;
            default: return longint'(r);
        endcase
    endfunction

    // Reference: plain integer average of everything accepted, round half up, saturate
    task automatic pushExpect();
        exp_t   e;
        longint r;
        e.avg = '0;
        for (int b = 0; b < BK; b++) begin
            r = (mSum[b] + 2048) >>> 12;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            e.avg[b*DW +: DW] = DW'(r);
        end
        e.err = (mCnt != 4096);
        e.cyc = cyc + 4;
        sbQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            i_writeEnable = 1'b0;
            i_finish      = 1'b0;
        end
    endtask

    task automatic beat(input int kind, input bit mask, input bit inWin, input bit fin);
        longint v;
        @(posedge i_clk); #1;
        for (int b = 0; b < BK; b++) begin
            for (int l = 0; l < LN; l++) begin
                if (l == 0 || mask) begin
                    v = inWin ? elemVal(kind, b, mCnt + l) : elemVal(4, b, 0);
                    if (inWin) mSum[b] += v;
                end else begin
                    v = elemVal(4, b, 0);
                end
                i_data[(b*LN+l)*DW +: DW] = DW'(v);
            end
        end
        if (inWin) mCnt += mask ? LN : 1;
        i_writeEnable = 1'b1;
        i_mask        = mask;
        i_finish      = fin;
        if (fin) pushExpect();
    endtask

    task automatic finishOnly(input bit expectResult);
        @(posedge i_clk); #1;
        i_writeEnable = 1'b0;
        i_finish      = 1'b1;
        if (expectResult) pushExpect();
    endtask

    task automatic clearWindow();
        @(posedge i_clk); #1;
        i_writeEnable  = 1'b0;
        i_finish       = 1'b0;
        i_resetAverage = 1'b0;
        @(posedge i_clk); #1;
        i_resetAverage = 1'b1;
        for (int b = 0; b < BK; b++) mSum[b] = 0;
        mCnt = 0;
    endtask

    task automatic waitResult();
        int k = 0;
        while (sbQ.size() != 0 && k < 12) begin
            idle(1);
            k++;
        end
        if (sbQ.size() != 0) begin
            check("valid_timeout", sbQ.size(), 0);
            sbQ.delete();
        end
        idle(2);
    endtask

    task automatic runWindow(input int kind, input int nFull, input bit partial,
                             input bit finWithBeat, input int gapPct);
        clearWindow();
        for (int i = 0; i < nFull; i++) begin
            if (gapPct > 0 && $urandom_range(99) < gapPct) idle(1);
            beat(kind, 1'b1, 1'b1, finWithBeat && !partial && (i == nFull - 1));
        end
        if (partial) beat(kind, 1'b0, 1'b1, finWithBeat);
        if (!finWithBeat) finishOnly(1'b1);
        waitResult();
    endtask

    initial begin
        for (int b = 0; b < BK; b++) mSum[b] = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_avg", longint'(o_avg), 0);
        check("reset_valid", longint'(o_valid), 0);
        check("reset_busy", longint'(o_busy), 0);
        check("reset_countErr", longint'(o_countErr), 0);
        i_reset = 1'b0;
        idle(2);

        runWindow(0, 455, 1'b1, 1'b0, 0);   // all +1, exact window
        runWindow(1, 455, 1'b1, 1'b0, 0);   // 3 / -2 / alternating extremes
        runWindow(2, 455, 1'b1, 1'b0, 0);   // +0.5 and just under -0.5
        runWindow(0, 455, 1'b0, 1'b0, 0);   // 4095 elements

        clearWindow();
        for (int i = 0; i < 100; i++) beat(4, 1'b1, 1'b1, 1'b0);
        runWindow(3, 455, 1'b1, 1'b0, 0);   // abandoned window then fresh +5

        // Finish with the last beat, then beats during DRAIN/ROUND/DONE must be ignored
        clearWindow();
        for (int i = 0; i < 455; i++) beat(3, 1'b1, 1'b1, 1'b0);
        beat(3, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) beat(4, 1'b1, 1'b0, 1'b0);
        waitResult();
        check("busy_after_done", longint'(o_busy), 0);

        // Async reset in the middle of DRAIN
        clearWindow();
        for (int i = 0; i < 20; i++) beat(3, 1'b1, 1'b1, 1'b0);
        finishOnly(1'b0);
        idle(1);
        i_reset = 1'b1;
        #1;
        check("drain_reset_avg", longint'(o_avg), 0);
        check("drain_reset_valid", longint'(o_valid), 0);
        check("drain_reset_busy", longint'(o_busy), 0);
        check("drain_reset_countErr", longint'(o_countErr), 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        idle(10);

        runWindow(0, 455, 1'b1, 1'b0, 0);   // recovery after reset
        runWindow(4, 470, 1'b0, 1'b0, 0);   // oversized window
        for (int w = 0; w < 4; w++)
            runWindow(4, $urandom_range(450, 460), 1'($urandom_range(1)), 1'($urandom_range(1)), 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
